food_spawner: RTL and testbench

//  Consumes the free-running 16-bit pseudo-random word from the LFSR and turns it into a

---
 rtl/food_spawner_if.sv | 32 +++
 rtl/food_spawner.sv | 128 ++++++++++++
 tb/tb_food_spawner.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/food_spawner_if.sv
// Handshake bundle between the food spawner, the LFSR, the occupancy store and the game FSM.
// The slave modport is the spawner's view; master is the environment driving it.
interface food_spawner_if #(
    parameter int RAND_W = 16,
    parameter int X_W    = 5,
    parameter int Y_W    = 5
);
    logic [RAND_W-1:0] i_random_in;
    logic              i_spawn_req;
    logic              i_occ_hit;
    logic              o_occ_query;
    logic [X_W-1:0]    o_occ_x;
    logic [Y_W-1:0]    o_occ_y;
    logic              o_busy;
    logic [X_W-1:0]    o_food_x;
    logic [Y_W-1:0]    o_food_y;
    logic              o_food_valid;
    logic              o_spawn_done;
    logic              o_spawn_fail;

    modport slave (
        input  i_random_in, i_spawn_req, i_occ_hit,
        output o_occ_query, o_occ_x, o_occ_y, o_busy,
               o_food_x, o_food_y, o_food_valid, o_spawn_done, o_spawn_fail
    );

    modport master (
        output i_random_in, i_spawn_req, i_occ_hit,
        input  o_occ_query, o_occ_x, o_occ_y, o_busy,
               o_food_x, o_food_y, o_food_valid, o_spawn_done, o_spawn_fail
    );
endinterface

// File: rtl/food_spawner.sv
// Places Snake food on a free grid cell: random candidates from the LFSR first,
// then a row-major scan after MAX_TRIES misses; reports fail when the grid is full.
module food_spawner #(
    parameter int RAND_W    = 16,
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int X_W       = 5,
    parameter int Y_W       = 5,
    parameter int MAX_TRIES = 16
) (
    input  logic           clk,
    input  logic           rst,
    food_spawner_if.slave  bus
);
    localparam int TW    = $clog2(MAX_TRIES + 1);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int CW    = $clog2(CELLS + 1);
    localparam logic [TW-1:0]  TMAX = TW'(MAX_TRIES);
    localparam logic [CW-1:0]  CMAX = CW'(CELLS);
    localparam logic [X_W-1:0] XMAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] YMAX = Y_W'(GRID_H - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SAMPLE, S_QUERY, S_WAIT, S_SCAN_Q, S_SCAN_W, S_SCAN_C, S_DONE, S_FAIL
    } state_t;

    state_t         r_state, w_next;
    logic [TW-1:0]  r_tries;
    logic [CW-1:0]  r_cnt;
    logic [X_W-1:0] r_x, r_food_x;
    logic [Y_W-1:0] r_y, r_food_y;
    logic           r_food_valid;

    logic [X_W-1:0] w_cx;
    logic [Y_W-1:0] w_cy;
    logic           w_off;
    logic [TW-1:0]  w_tries_nx;
    logic           w_unused_rand;

    assign w_cx          = bus.i_random_in[X_W-1:0];
    assign w_cy          = bus.i_random_in[X_W+Y_W-1:X_W];
    assign w_off         = (32'(w_cx) >= GRID_W) || (32'(w_cy) >= GRID_H);
    assign w_tries_nx    = r_tries + TW'(1);
    assign w_unused_rand = ^bus.i_random_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.i_spawn_req) w_next = S_SAMPLE;
            S_SAMPLE: if (!w_off)                w_next = S_QUERY;
                      else if (w_tries_nx == TMAX) w_next = S_SCAN_Q;
            S_QUERY:  w_next = S_WAIT;
            S_WAIT:   if (!bus.i_occ_hit)    w_next = S_DONE;
                      else if (r_tries == TMAX) w_next = S_SCAN_Q;
                      else                   w_next = S_SAMPLE;
            S_SCAN_Q: w_next = S_SCAN_W;
            S_SCAN_W: w_next = bus.i_occ_hit ? S_SCAN_C : S_DONE;
            S_SCAN_C: w_next = (r_cnt == CMAX) ? S_FAIL : S_SCAN_Q;
            S_DONE:   w_next = S_IDLE;
            S_FAIL:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // r_x/r_y hold the current candidate, and double as the scan cursor once scanning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tries      <= '0;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_food_x     <= '0;
            r_food_y     <= '0;
            r_food_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.i_spawn_req) begin
                    r_tries      <= '0;
                    r_food_valid <= 1'b0;
                end
                S_SAMPLE: begin
                    r_tries <= w_tries_nx;
                    r_cnt   <= '0;
                    if (w_off && w_tries_nx == TMAX) begin
                        r_x <= '0;
                        r_y <= '0;
                    end else begin
                        r_x <= w_cx;
                        r_y <= w_cy;
                    end
                end
                S_WAIT: r_cnt <= '0;
                S_SCAN_W: if (bus.i_occ_hit) begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_x == XMAX) begin
                        r_x <= '0;
                        r_y <= (r_y == YMAX) ? '0 : r_y + Y_W'(1);
                    end else begin
                        r_x <= r_x + X_W'(1);
                    end
                end
                S_DONE: begin
                    r_food_x     <= r_x;
                    r_food_y     <= r_y;
                    r_food_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.o_occ_query  = (r_state == S_QUERY) || (r_state == S_SCAN_Q);
        bus.o_occ_x      = bus.o_occ_query ? r_x : '0;
        bus.o_occ_y      = bus.o_occ_query ? r_y : '0;
        bus.o_busy       = (r_state != S_IDLE);
        bus.o_spawn_done = (r_state == S_DONE);
        bus.o_spawn_fail = (r_state == S_FAIL);
        bus.o_food_x     = r_food_x;
        bus.o_food_y     = r_food_y;
        bus.o_food_valid = r_food_valid;
    end
endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: a vector table of single spawns plus hand-written
// sequences for reject timing, requests while busy and reset mid-operation.
module tb_food_spawner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    food_spawner_if #(.RAND_W(16), .X_W(5), .Y_W(5)) bus();

    food_spawner dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int mode  = 0;   // 0: grid empty, 1: grid full, 2: only (4,0) free
    int qcount = 0;
    int offq   = 0;

    function automatic logic occupied(input logic [4:0] x, input logic [4:0] y);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return !(x == 5'd4 && y == 5'd0);
        endcase
    endfunction

    // Occupancy store: answers one cycle after a query, drives 1 when not answering.
    always @(posedge clk) begin
        bus.i_occ_hit <= bus.o_occ_query ? occupied(bus.o_occ_x, bus.o_occ_y) : 1'b1;
        if (bus.o_occ_query) begin
            qcount <= qcount + 1;
            if (bus.o_occ_y >= 5'd24) offq <= offq + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_spawn(input logic [15:0] rnd, output int lat, output bit ok, output bit fl);
        @(negedge clk);
        bus.i_random_in = rnd;
        bus.i_spawn_req = 1'b1;
        @(negedge clk);
        bus.i_spawn_req = 1'b0;
        lat = 1; ok = 1'b0; fl = 1'b0;
        chk("valid_cleared", int'(bus.o_food_valid), 0);
        chk("busy_c1", int'(bus.o_busy), 1);
        while (lat < 4000) begin
            if (bus.o_spawn_done) begin ok = 1'b1; break; end
            if (bus.o_spawn_fail) begin fl = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        if (!ok && !fl) chk("timeout", 0, 1);
    endtask

    typedef struct {
        logic [15:0] rnd;
        int mode;
        int ex;
        int ey;
        int fl;
        int lat;
        int nq;
    } vec_t;

    vec_t vt[8];

    initial begin
        int lat, q0, o0, cyc, ndone;
        bit ok, fl;

        vt[0] = '{16'h0025, 0, 5, 1, 0, 4, 1};
        vt[1] = '{16'hFC25, 0, 5, 1, 0, 4, 1};
        vt[2] = '{16'h02FF, 0, 31, 23, 0, 4, 1};
        vt[3] = '{16'h02E0, 0, 0, 23, 0, 4, 1};
        vt[4] = '{16'h0300, 0, 0, 0, 0, 19, 1};
        vt[5] = '{16'h03FF, 0, 0, 0, 0, 19, 1};
        vt[6] = '{16'h0002, 2, 4, 0, 0, 57, 19};
        vt[7] = '{16'h0025, 1, 4, 0, 1, 2353, 784};

        bus.i_random_in = '0;
        bus.i_spawn_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_valid", int'(bus.o_food_valid), 0);
        chk("rst_food", int'({bus.o_food_x, bus.o_food_y}), 0);
        chk("rst_query", int'(bus.o_occ_query), 0);
        chk("rst_pulses", int'({bus.o_spawn_done, bus.o_spawn_fail}), 0);
        rst = 1'b0;

        foreach (vt[i]) begin
            mode = vt[i].mode;
            q0 = qcount;
            o0 = offq;
            run_spawn(vt[i].rnd, lat, ok, fl);
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d_fail", i), int'(fl), vt[i].fl);
            chk($sformatf("v%0d_done", i), int'(ok), 1 - vt[i].fl);
            @(negedge clk);
            chk($sformatf("v%0d_food_x", i), int'(bus.o_food_x), vt[i].ex);
            chk($sformatf("v%0d_food_y", i), int'(bus.o_food_y), vt[i].ey);
            chk($sformatf("v%0d_valid", i), int'(bus.o_food_valid), 1 - vt[i].fl);
            chk($sformatf("v%0d_idle", i), int'(bus.o_busy), 0);
            chk($sformatf("v%0d_queries", i), qcount - q0, vt[i].nq);
            chk($sformatf("v%0d_offgrid_q", i), offq - o0, 0);
        end

        // Three off-grid rows (y=28) then (3,2): rejects cost one cycle each, never queried.
        mode = 0;
        q0 = qcount;
        o0 = offq;
        @(negedge clk);
        bus.i_random_in = 16'h0380;
        bus.i_spawn_req = 1'b1;
        @(negedge clk);
        bus.i_spawn_req = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_random_in = 16'h0043;
        cyc = 4;
        while (!bus.o_spawn_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("reject_latency", cyc, 7);
        @(negedge clk);
        chk("reject_queries", qcount - q0, 1);
        chk("reject_offgrid_q", offq - o0, 0);
        chk("reject_food", int'({bus.o_food_x, bus.o_food_y}), int'({5'd3, 5'd2}));
        chk("reject_valid", int'(bus.o_food_valid), 1);

        // Second request while busy must be dropped.
        @(negedge clk);
        bus.i_random_in = 16'h0025;
        bus.i_spawn_req = 1'b1;
        @(negedge clk);
        bus.i_spawn_req = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 15; c++) begin
            if (bus.o_spawn_done) ndone++;
            if (c == 2) begin
                bus.i_spawn_req = 1'b1;
                bus.i_random_in = 16'h0043;
            end else begin
                bus.i_spawn_req = 1'b0;
            end
            @(negedge clk);
        end
        chk("busy_req_done_count", ndone, 1);
        chk("busy_req_food", int'({bus.o_food_x, bus.o_food_y}), int'({5'd5, 5'd1}));
        chk("busy_req_idle", int'(bus.o_busy), 0);

        // Reset asserted in WAIT.
        @(negedge clk);
        bus.i_random_in = 16'h0043;
        bus.i_spawn_req = 1'b1;
        @(negedge clk);
        bus.i_spawn_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("wait_busy", int'(bus.o_busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(bus.o_busy), 0);
        chk("midrst_food", int'({bus.o_food_x, bus.o_food_y}), 0);
        chk("midrst_valid", int'(bus.o_food_valid), 0);
        chk("midrst_query", int'(bus.o_occ_query), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.o_spawn_done || bus.o_spawn_fail || bus.o_busy) ndone++;
        end
        chk("midrst_quiet", ndone, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
